stage_if_pipelined: RTL and testbench

- Parametrised instruction-fetch stage for the five-stage pipeline CPU.
- Owns the PC, drives a synchronous instruction memory with fixed 1-cycle read latency, and registers the fetched instruction into the IF/ID boundary.
- Supports redirect from EX/MEM (branch/jump), hazard-unit stall, and a wrapping per-instruction sequence tag.
- Adds decoupled fetch and valid, stall and flush handling.

---
 rtl/stage_if_pipelined.sv | 70 +++++++
 tb/tb_stage_if_pipelined.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stage_if_pipelined.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory and registers the fetched word into the IF/ID boundary.
module stage_if_pipelined #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned PC_STEP    = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned SEQ_WIDTH  = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INST = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_next,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [SEQ_WIDTH-1:0]  if_seq
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pending_pc;
  logic                  pending_valid;
  logic [SEQ_WIDTH-1:0]  seq_count;

  always_comb begin
    imem_en    = !stall && !redirect_valid;
    imem_addr  = pc;
    if_pc_next = if_pc + STEP;
  end

  // seq_count is the tag the next valid entry receives, so the first
  // instruction after reset carries tag 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      pending_pc    <= '0;
      pending_valid <= 1'b0;
      if_valid      <= 1'b0;
      if_pc         <= '0;
      if_inst       <= NOP_INST;
      if_seq        <= '0;
      seq_count     <= '0;
    end else if (redirect_valid) begin
      pc            <= redirect_target;
      pending_valid <= 1'b0;
      if_valid      <= 1'b0;
      if_inst       <= NOP_INST;
    end else if (!stall) begin
      pending_pc    <= pc;
      pending_valid <= 1'b1;
      pc            <= pc + STEP;
      if_valid      <= pending_valid;
      if_pc         <= pending_pc;
      if_inst       <= pending_valid ? imem_rdata : NOP_INST;
      if (pending_valid) begin
        if_seq    <= seq_count;
        seq_count <= seq_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_if_pipelined.sv
// Directed bench for stage_if_pipelined with a behavioural synchronous
// instruction memory returning 0x100 + address.
module tb_stage_if_pipelined;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;
  logic [31:0] if_inst;
  logic [3:0]  if_seq;

  int tests = 0;
  int fails = 0;

  stage_if_pipelined #(
    .ADDR_WIDTH(32),
    .INST_WIDTH(32),
    .PC_STEP(1),
    .RESET_PC(32'h0),
    .SEQ_WIDTH(4),
    .NOP_INST(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_pc_next(if_pc_next),
    .if_inst(if_inst),
    .if_seq(if_seq)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (imem_en) imem_rdata <= 32'h100 + imem_addr;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] inst, input logic [3:0] seq);
    check({tag, ".valid"}, 64'(if_valid), 64'(v));
    check({tag, ".pc"},    64'(if_pc),    64'(pc));
    check({tag, ".inst"},  64'(if_inst),  64'(inst));
    check({tag, ".seq"},   64'(if_seq),   64'(seq));
  endtask

  task automatic check_reset(input string tag);
    check_out(tag, 1'b0, 32'h0, 32'h0, 4'h0);
    check({tag, ".pc_next"}, 64'(if_pc_next), 64'h1);
    check({tag, ".addr"},    64'(imem_addr),  64'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #12;
    check_reset("rst");
    reset = 1'b0;

    // Startup latency and steady stream
    step(); check("e1.valid", 64'(if_valid), 64'h0);
    step(); check_out("e2", 1'b1, 32'h0, 32'h100, 4'h0);
    check("e2.pc_next", 64'(if_pc_next), 64'h1);
    step(); check_out("s1", 1'b1, 32'h1, 32'h101, 4'h1);
    step(); check_out("s2", 1'b1, 32'h2, 32'h102, 4'h2);

    // Stall three cycles at if_pc=2
    stall = 1'b1;
    #1 check("stall.en", 64'(imem_en), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step(); check_out("stall", 1'b1, 32'h2, 32'h102, 4'h2);
    end
    stall = 1'b0;
    step(); check_out("rel1", 1'b1, 32'h3, 32'h103, 4'h3);
    step(); check_out("rel2", 1'b1, 32'h4, 32'h104, 4'h4);
    step(); check_out("rel3", 1'b1, 32'h5, 32'h105, 4'h5);

    // Redirect to 0x40
    redirect_valid = 1'b1; redirect_target = 32'h40;
    #1 check("redir.en", 64'(imem_en), 64'h0);
    step(); check_out("redir1", 1'b0, 32'h5, 32'h0, 4'h5);
    redirect_valid = 1'b0;
    step(); check("redir2.valid", 64'(if_valid), 64'h0);
    step(); check_out("redir3", 1'b1, 32'h40, 32'h140, 4'h6);
    check("redir3.pc_next", 64'(if_pc_next), 64'h41);

    // Redirect with stall held
    redirect_valid = 1'b1; redirect_target = 32'h80; stall = 1'b1;
    step(); check("rs1.valid", 64'(if_valid), 64'h0);
    check("rs1.addr", 64'(imem_addr), 64'h80);
    redirect_valid = 1'b0;
    step(); step();
    check("rs2.valid", 64'(if_valid), 64'h0);
    check("rs2.addr", 64'(imem_addr), 64'h80);
    stall = 1'b0;
    step(); check("rs3.valid", 64'(if_valid), 64'h0);
    step(); check_out("rs4", 1'b1, 32'h80, 32'h180, 4'h7);

    // Back-to-back redirects: last target wins
    redirect_valid = 1'b1; redirect_target = 32'h10;
    step();
    redirect_target = 32'h20;
    step(); check("bb.valid", 64'(if_valid), 64'h0);
    redirect_valid = 1'b0;
    step(); check("bb2.valid", 64'(if_valid), 64'h0);
    step(); check_out("bb3", 1'b1, 32'h20, 32'h120, 4'h8);

    // PC wrap at all-ones
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    step(); check("wrap.addr", 64'(imem_addr), 64'h0);
    step(); check_out("wrap1", 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF, 4'h9);
    check("wrap1.pc_next", 64'(if_pc_next), 64'h0);
    step(); check_out("wrap2", 1'b1, 32'h0, 32'h100, 4'hA);

    // Asynchronous reset between edges
    #3 reset = 1'b1;
    #1 check_reset("arst");
    #2 reset = 1'b0;
    step(); check("ar1.valid", 64'(if_valid), 64'h0);
    step(); check_out("ar2", 1'b1, 32'h0, 32'h100, 4'h0);

    // Sequence tag wraps after 16 deliveries
    for (int i = 0; i < 15; i++) step();
    check_out("seq15", 1'b1, 32'hF, 32'h10F, 4'hF);
    step(); check_out("seqwrap", 1'b1, 32'h10, 32'h110, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
